// File: rtl/sd_cmd_resp_rx.sv
// ============================================================================
// Module   : sd_cmd_resp_rx
// Purpose  : SD/SDIO command-line response receiver: start-bit hunt, frame
//            capture, CRC7/end-bit check, valid/ready hand-off.
// Options  : SD_RESP_LONG_EN adds resp_long and 136-bit R2 frame capture.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sd_cmd_resp_rx #(
   parameter int RESP_BITS = 48,
   parameter int NCR_MAX   = 64,
`ifdef SD_RESP_LONG_EN
   localparam int DATA_W   = 136
`else
   localparam int DATA_W   = RESP_BITS
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_en,
   input  logic              sdio_cmd_i,
   input  logic              arm,
   input  logic              crc_skip,
`ifdef SD_RESP_LONG_EN
   input  logic              resp_long,
`endif
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              crc_err,
   output logic              frame_err,
   output logic              timeout,
   output logic              busy
);

   localparam int BCW = $clog2(DATA_W + 1);
   localparam int NCW = $clog2(NCR_MAX + 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      RECEIVE    = 2'd2,
      DONE       = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [NCW-1:0]    ncr_cnt_q, ncr_cnt_d;
   logic [6:0]        crc_q, crc_d;
   logic              skip_q, skip_d;
   logic              crc_err_q, crc_err_d;
   logic              frame_err_q, frame_err_d;
   logic              timeout_q, timeout_d;
   logic [BCW-1:0]    frame_top;
   logic [BCW-1:0]    crc_top;
   logic              crc_en;

   // bit_cnt holds (index of next frame bit + 1); frame_top is loaded at the start bit.
`ifdef SD_RESP_LONG_EN
   logic long_q, long_d;
   assign frame_top = long_q ? BCW'(135) : BCW'(RESP_BITS - 1);
   assign crc_top   = long_q ? BCW'(128) : BCW'(RESP_BITS - 1);
`else
   assign frame_top = BCW'(RESP_BITS - 1);
   assign crc_top   = BCW'(RESP_BITS - 1);
`endif

   assign crc_en = (bit_cnt_q >= BCW'(9)) && (bit_cnt_q <= crc_top);

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic din);
      logic fb;
      fb = c[6] ^ din;
      return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         data_q      <= '0;
         bit_cnt_q   <= '0;
         ncr_cnt_q   <= '0;
         crc_q       <= '0;
         skip_q      <= 1'b0;
         crc_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         timeout_q   <= 1'b0;
`ifdef SD_RESP_LONG_EN
         long_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         bit_cnt_q   <= bit_cnt_d;
         ncr_cnt_q   <= ncr_cnt_d;
         crc_q       <= crc_d;
         skip_q      <= skip_d;
         crc_err_q   <= crc_err_d;
         frame_err_q <= frame_err_d;
         timeout_q   <= timeout_d;
`ifdef SD_RESP_LONG_EN
         long_q      <= long_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      bit_cnt_d   = bit_cnt_q;
      ncr_cnt_d   = ncr_cnt_q;
      crc_d       = crc_q;
      skip_d      = skip_q;
      crc_err_d   = crc_err_q;
      frame_err_d = frame_err_q;
      timeout_d   = timeout_q;
`ifdef SD_RESP_LONG_EN
      long_d      = long_q;
`endif
      case (state_q)
         IDLE: begin
            if (arm) begin
               state_d   = WAIT_START;
               skip_d    = crc_skip;
               ncr_cnt_d = '0;
`ifdef SD_RESP_LONG_EN
               long_d    = resp_long;
`endif
            end
         end
         WAIT_START: begin
            if (sample_en) begin
               if (!sdio_cmd_i) begin
                  // Clearing is equivalent to shifting the start 0 into a fresh frame.
                  data_d    = '0;
                  bit_cnt_d = frame_top;
                  crc_d     = '0;
                  state_d   = RECEIVE;
               end else if (ncr_cnt_q == NCW'(NCR_MAX - 1)) begin
                  timeout_d = 1'b1;
                  state_d   = DONE;
               end else begin
                  ncr_cnt_d = ncr_cnt_q + NCW'(1);
               end
            end
         end
         RECEIVE: begin
            if (sample_en) begin
               data_d    = {data_q[DATA_W-2:0], sdio_cmd_i};
               bit_cnt_d = bit_cnt_q - BCW'(1);
               if (crc_en) begin
                  crc_d = crc7_step(crc_q, sdio_cmd_i);
               end
               if (bit_cnt_q == BCW'(1)) begin
                  // data_q[6:0] already holds frame bits 7..1, the transmitted CRC.
                  crc_err_d   = (crc_q != data_q[6:0]) && !skip_q;
                  frame_err_d = !sdio_cmd_i;
                  state_d     = DONE;
               end
            end
         end
         DONE: begin
            if (resp_ready) begin
               crc_err_d   = 1'b0;
               frame_err_d = 1'b0;
               timeout_d   = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign resp_data  = data_q;
   assign resp_valid = (state_q == DONE);
   assign crc_err    = crc_err_q;
   assign frame_err  = frame_err_q;
   assign timeout    = timeout_q;
   assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire
